keypad_scan_reader: RTL and testbench
=====================================

Name: keypad_scan_reader

Overview:
- Scans a 4x4 passive key matrix and reports debounced key presses.
- It is the input-side counterpart of the seven-segment anode scanning chain. The display scanner drives multiplexed outputs; this block drives columns one at a time and reads the rows back.
- Output is a one-cycle press strobe, a 4-bit key code and a held flag, all synchronous to clk. These feed the digit/hex display path.

Parameters:
- SCAN_DIV, 4096, clk cycles each column is driven (dwell); legal minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- row_in  input  4  matrix rows, active-low (pulled up externally), asynchronous to clk
- col_out  output  4  matrix column drive, active-low one-hot
- key_valid  output  1  one-cycle pulse on accepted press
- key_code  output  4  code of last accepted key, held until next press
- key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset values (asserted asynchronously):
  - col_out=4'b1110 (column 0 driven).
  - dwell counter=0, column index=0.
  - synchronizer flops=4'b1111.
  - scan accumulator cleared.
  - key_valid=0, key_code=0, key_held=0.
  - stability count=0, state IDLE.
- Synchronizer: row_in passes through a 2-flop synchronizer before use.
- Column sequencing:
  - Dwell counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, column index increments modulo 4: 3 wraps to 0.
  - col_out = ~(4'b0001 << column index).
- Row sampling:
  - Synchronized rows are sampled on the last dwell cycle (count==SCAN_DIV-1) of each column. This gives at least 2 cycles of settle plus synchronizer latency after each column change.
  - A low row bit r while column c is driven is a hit; key code = 4*r + c.
- Scan result:
  - A full scan is the 4 column samples, columns 0..3. It is evaluated at the column-3 sample.
  - Zero hits -> NONE; exactly one hit -> KEY(code); two or more hits -> MULTI.
  - The accumulator clears for the next scan.
- Debounce FSM (advances only on scan-end events, otherwise holds):
  - IDLE: KEY(k) -> CANDIDATE, cand=k, count=1. NONE/MULTI -> stay.
  - CANDIDATE:
    - KEY(cand) -> count+1.
    - When count reaches DEBOUNCE_SCANS: go PRESSED, key_code=cand, key_valid=1 for exactly the next cycle, key_held=1.
    - KEY(other) -> restart with cand=other, count=1.
    - NONE or MULTI -> IDLE, count=0.
    - If DEBOUNCE_SCANS=1, the IDLE->CANDIDATE scan accepts immediately (direct to PRESSED).
  - PRESSED:
    - NONE -> RELEASING, count=1. KEY(any)/MULTI -> stay, no new strobe.
    - A second key added while one is held (MULTI) or a key swap is not reported until full release.
  - RELEASING:
    - NONE -> count+1. At DEBOUNCE_SCANS: go IDLE, key_held=0.
    - Any KEY/MULTI -> back to PRESSED, count=0.
    - If DEBOUNCE_SCANS=1, release is accepted on the PRESSED->RELEASING scan (direct to IDLE).
- Timing:
  - key_valid never asserts on consecutive cycles.
  - key_valid and the key_code update occur in the same cycle.
  - Minimum press latency = DEBOUNCE_SCANS full scans after the first scan containing the key, plus 1 cycle.
- Reset mid-scan: all state returns to reset values immediately; a key held through reset must be re-debounced from IDLE.
- Counter widths: dwell counter is $clog2(SCAN_DIV) bits; stability count is 4 bits, saturating at DEBOUNCE_SCANS.

Test Plan:
- Idle after reset, SCAN_DIV=4, DEBOUNCE_SCANS=3, row_in=4'b1111 for 200 cycles:
  - col_out cycles 1110,1101,1011,0111, each held 4 cycles.
  - key_valid never asserts; key_held=0; key_code=0.
- Clean press, same parameters, pulling row 1 low only while column 2 is driven, starting before scan 0:
  - key_valid pulses once one cycle after the end of the 3rd scan.
  - key_code=6; key_held=1.
  - Holding for 10 more scans gives no further pulse.
- Release: from the held state, stop pulling row 1 low:
  - key_held falls one cycle after the 3rd consecutive NONE scan end.
  - key_code stays 6.
- Bounce, same parameters, key 6 present for 2 scans, absent 1, present 2:
  - No key_valid.
  - Then present for 3 scans -> single pulse, key_code=6.
- Multiple keys, same parameters, keys 5 and 10 both pressed for 6 scans:
  - No key_valid.
  - Release key 10 -> pulse with key_code=5 after 3 further scans.
- Async reset mid-operation: assert rst for 3 cycles while in PRESSED with key 6 held:
  - Outputs go to reset values immediately.
  - After rst deassert with key still held -> new key_valid after 3 scans.

Source files
------------

// File: rtl/keypad_scan_reader.sv
// keypad_scan_reader: drives a 4x4 key matrix one column at a time and reads the rows back.
// Each full scan is classified as no key, one key or several keys. A debounce FSM then turns
// the scan results into a press strobe, the code of the last key and a held flag.
module keypad_scan_reader #(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int              CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB        = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED, RELEASING} state_t;

  logic [CW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  logic [3:0]    col_out_reg;
  logic [3:0]    sync1_reg, sync2_reg;
  // Hit count for the scan so far: 0 = none, 1 = single key, 2 = several keys.
  logic [1:0]    acc_cnt_reg;
  logic [3:0]    acc_code_reg;

  state_t        state_reg, state_next;
  logic [3:0]    stab_reg, stab_next;
  logic [3:0]    cand_reg, cand_next;
  logic          key_valid_reg, key_valid_next;
  logic [3:0]    key_code_reg, key_code_next;
  logic          key_held_reg, key_held_next;

  logic          sample, scan_end;
  logic [3:0]    col_hits;
  logic [2:0]    col_cnt;
  logic [1:0]    col_row;
  logic [1:0]    res_cnt;
  logic [3:0]    res_code;
  logic [3:0]    stab_inc;

  assign col_out   = col_out_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_held  = key_held_reg;

  assign sample   = (dwell_reg == DWELL_LAST);
  assign scan_end = sample && (col_idx_reg == 2'd3);

  // The rows are asynchronous to clk, so they pass through two flops before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 4'b1111;
      sync2_reg <= 4'b1111;
    end else begin
      sync1_reg <= row_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Dwell counter and column drive. col_out is registered so the matrix never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_reg   <= '0;
      col_idx_reg <= 2'd0;
      col_out_reg <= 4'b1110;
    end else if (sample) begin
      dwell_reg   <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
      col_out_reg <= ~(4'b0001 << (col_idx_reg + 2'd1));
    end else begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

  // Decode the current column: count the low rows and find the lowest one.
  always_comb begin
    col_hits = ~sync2_reg;
    col_cnt  = {2'b00, col_hits[0]} + {2'b00, col_hits[1]} +
               {2'b00, col_hits[2]} + {2'b00, col_hits[3]};
    col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (col_hits[r]) col_row = 2'(r);
    end
  end

  // Merge this column into the running scan result. Any second hit makes the result MULTI.
  always_comb begin
    res_cnt  = 2'd0;
    res_code = acc_code_reg;
    if (acc_cnt_reg == 2'd2 || col_cnt >= 3'd2 || (acc_cnt_reg == 2'd1 && col_cnt == 3'd1)) begin
      res_cnt = 2'd2;
    end else if (acc_cnt_reg == 2'd1) begin
      res_cnt = 2'd1;
    end else if (col_cnt == 3'd1) begin
      res_cnt  = 2'd1;
      res_code = {col_row, col_idx_reg};
    end
  end

  // Scan accumulator: updated at each column sample and cleared once the scan is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_reg  <= 2'd0;
      acc_code_reg <= 4'd0;
    end else if (scan_end) begin
      acc_cnt_reg  <= 2'd0;
      acc_code_reg <= 4'd0;
    end else if (sample) begin
      acc_cnt_reg  <= res_cnt;
      acc_code_reg <= res_code;
    end
  end

  // Debounce state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      stab_reg      <= 4'd0;
      cand_reg      <= 4'd0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stab_reg      <= stab_next;
      cand_reg      <= cand_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      key_held_reg  <= key_held_next;
    end
  end

  // Debounce next-state logic. It acts only on scan-end events and holds otherwise.
  always_comb begin
    state_next     = state_reg;
    stab_next      = stab_reg;
    cand_next      = cand_reg;
    key_valid_next = 1'b0;
    key_code_next  = key_code_reg;
    key_held_next  = key_held_reg;
    stab_inc       = (stab_reg >= DEB) ? DEB : stab_reg + 4'd1;
    if (scan_end) begin
      case (state_reg)
        IDLE: begin
          if (res_cnt == 2'd1) begin
            if (DEB <= 4'd1) begin
              state_next     = PRESSED;
              stab_next      = 4'd0;
              key_code_next  = res_code;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end else begin
              state_next = CANDIDATE;
              cand_next  = res_code;
              stab_next  = 4'd1;
            end
          end
        end
        CANDIDATE: begin
          if (res_cnt == 2'd1 && res_code == cand_reg) begin
            if (stab_inc >= DEB) begin
              state_next     = PRESSED;
              stab_next      = 4'd0;
              key_code_next  = cand_reg;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end else begin
              stab_next = stab_inc;
            end
          end else if (res_cnt == 2'd1) begin
            cand_next = res_code;
            stab_next = 4'd1;
          end else begin
            state_next = IDLE;
            stab_next  = 4'd0;
          end
        end
        PRESSED: begin
          if (res_cnt == 2'd0) begin
            if (DEB <= 4'd1) begin
              state_next    = IDLE;
              stab_next     = 4'd0;
              key_held_next = 1'b0;
            end else begin
              state_next = RELEASING;
              stab_next  = 4'd1;
            end
          end
        end
        RELEASING: begin
          if (res_cnt == 2'd0) begin
            if (stab_inc >= DEB) begin
              state_next    = IDLE;
              stab_next     = 4'd0;
              key_held_next = 1'b0;
            end else begin
              stab_next = stab_inc;
            end
          end else begin
            state_next = PRESSED;
            stab_next  = 4'd0;
          end
        end
        default: begin
          state_next = IDLE;
          stab_next  = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Bench for keypad_scan_reader with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
// A behavioural key matrix pulls a row low while its key is pressed and its column is driven.
// Each expected press (code plus the cycle it should strobe in) goes into a queue. A monitor
// pops the queue on every key_valid and compares against it.
module tb_keypad_scan_reader;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys;
  int          cyc;
  int          total;
  int          bad;
  logic        prev_kv;
  logic [3:0]  exp_col;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  keypad_scan_reader #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix model: key 4*r+c shorts row r to column c.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Cycle count since the last reset release (0 in the first cycle after release).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic at_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_col_out", {28'd0, col_out}, 32'hE);
    check("rst_key_valid", {31'd0, key_valid}, 0);
    check("rst_key_code", {28'd0, key_code}, 0);
    check("rst_key_held", {31'd0, key_held}, 0);
  endtask

  // Reset is asserted between clock edges. The outputs must clear before the next edge.
  task automatic do_reset(input logic [15:0] k);
    keys = k;
    rst  = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every strobe must match the head of the queue in both code and cycle.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      check("kv_not_consecutive", {31'd0, prev_kv}, 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: key_code=%0d at cyc %0d, required no pulse", key_code, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
        check("pulse_cycle", cyc, e.at);
        check("pulse_held", {31'd0, key_held}, 1);
      end
    end
    prev_kv = key_valid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    total   = 0;
    bad     = 0;
    prev_kv = 1'b0;
    keys    = 16'h0000;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Idle: the columns rotate every 4 cycles and nothing is reported.
    for (int i = 0; i < 200; i++) begin
      exp_col = ~(4'b0001 << ((cyc / 4) % 4));
      check("idle_col_out", {28'd0, col_out}, {28'd0, exp_col});
      @(negedge clk);
    end
    check("idle_key_held", {31'd0, key_held}, 0);
    check("idle_key_code", {28'd0, key_code}, 0);
    check_sb_empty("idle_no_pulse");

    // Clean press of key 6: accepted at the end of scan 2, held 10 more scans, then released.
    do_reset(16'h0040);
    sb.push_back('{code: 4'd6, at: 48});
    at_cycle(49);
    check("press_held", {31'd0, key_held}, 1);
    check("press_code", {28'd0, key_code}, 6);
    at_cycle(208);
    keys = 16'h0000;
    at_cycle(255);
    check("release_still_held", {31'd0, key_held}, 1);
    at_cycle(256);
    check("release_held_low", {31'd0, key_held}, 0);
    check("release_code_kept", {28'd0, key_code}, 6);
    check_sb_empty("press_single_pulse");

    // Bounce: present 2 scans, absent 1, present 2, absent 1, then present 3 scans.
    do_reset(16'h0040);
    at_cycle(32);  keys = 16'h0000;
    at_cycle(48);  keys = 16'h0040;
    at_cycle(80);  keys = 16'h0000;
    at_cycle(96);
    check("bounce_no_press", {31'd0, key_held}, 0);
    keys = 16'h0040;
    sb.push_back('{code: 4'd6, at: 144});
    at_cycle(150);
    check("bounce_held", {31'd0, key_held}, 1);
    check("bounce_code", {28'd0, key_code}, 6);
    check_sb_empty("bounce_pulse");

    // Keys 5 and 10 together for 6 scans, then key 10 is released.
    do_reset(16'h0420);
    at_cycle(96);
    check("multi_no_press", {31'd0, key_held}, 0);
    keys = 16'h0020;
    sb.push_back('{code: 4'd5, at: 144});
    at_cycle(150);
    check("multi_held", {31'd0, key_held}, 1);
    check("multi_code", {28'd0, key_code}, 5);
    check_sb_empty("multi_pulse");

    // Reset while key 6 is held: the key has to be debounced again from scratch.
    do_reset(16'h0040);
    sb.push_back('{code: 4'd6, at: 48});
    at_cycle(60);
    check("pre_reset_held", {31'd0, key_held}, 1);
    check_sb_empty("pre_reset_pulse");
    do_reset(16'h0040);
    sb.push_back('{code: 4'd6, at: 48});
    at_cycle(60);
    check("post_reset_held", {31'd0, key_held}, 1);
    check("post_reset_code", {28'd0, key_code}, 6);
    check_sb_empty("post_reset_pulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
